// File: rtl/sram8_bridge.sv
// rtl/sram8_bridge.sv - 32-bit word requests served as byte cycles on an 8-bit async SRAM
// Optional per-byte HOLD phase enabled by defining SRAM8_BRIDGE_HOLD_EN.
module sram8_bridge #(
    parameter int ADDR_W = 19,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic [3:0]        we,
    input  logic [29:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        rem_q, rem_d;
    logic [1:0]        byte_q, byte_d;
    logic              wr_q, wr_d;
    logic [29:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] sa_q, sa_d;
    logic [7:0]        dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [3:0]        rem_left;
    logic              active;

    function automatic logic [1:0] first_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        byte_d   = byte_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rem_left = rem_q & ~(4'b0001 << byte_q);
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (re) begin
                    state_d = SETUP;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = |we;
                    rem_d   = (we == 4'b0000) ? 4'b1111 : we;
                    byte_d  = first_set(rem_d);
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 4'd0;
            end
            STROBE: begin
                if (cnt_q == WAIT_C) begin
                    if (!wr_q) rdata_d[{byte_q, 3'b000} +: 8] = sram_dq_in;
                    rem_d = rem_left;
`ifdef SRAM8_BRIDGE_HOLD_EN
                    state_d = HOLD;
`else
                    state_d = (rem_left == 4'b0000) ? DONE : SETUP;
                    byte_d  = first_set(rem_left);
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`ifdef SRAM8_BRIDGE_HOLD_EN
            HOLD: begin
                // rem_q already excludes the byte just strobed
                state_d = (rem_q == 4'b0000) ? DONE : SETUP;
                byte_d  = first_set(rem_q);
            end
`endif
            default: state_d = IDLE;
        endcase

        // Output registers load from next-state values so pins change cleanly on the clock edge
        active = (state_d == SETUP) || (state_d == STROBE);
`ifdef SRAM8_BRIDGE_HOLD_EN
        if (state_d == HOLD) active = 1'b1;
`endif
        ready_d  = (state_d == DONE);
        ce_n_d   = !active;
        oe_n_d   = !((state_d == STROBE) && !wr_d);
        we_n_d   = !((state_d == STROBE) && wr_d);
        dq_oe_d  = active && wr_d;
        sa_d     = active ? ADDR_W'({addr_d, byte_d}) : sa_q;
        dq_out_d = (active && wr_d) ? wdata_d[{byte_d, 3'b000} +: 8] : dq_out_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rem_q    <= 4'd0;
            byte_q   <= 2'd0;
            wr_q     <= 1'b0;
            addr_q   <= 30'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            sa_q     <= '0;
            dq_out_q <= 8'd0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            byte_q   <= byte_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            sa_q     <= sa_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
        end
    end

    assign rdata       = rdata_q;
    assign mem_ready   = ready_q;
    assign sram_addr   = sa_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram8_bridge.sv
// tb/tb_sram8_bridge.sv - randomized scoreboard bench for sram8_bridge (honours SRAM8_BRIDGE_HOLD_EN)
module tb_sram8_bridge;
    localparam int AW    = 10;
    localparam int WT    = 1;
    localparam int MEMSZ = 1 << AW;
`ifdef SRAM8_BRIDGE_HOLD_EN
    localparam int B = WT + 3;
`else
    localparam int B = WT + 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          re = 1'b0;
    logic [3:0]    we = 4'd0;
    logic [29:0]   addr = 30'd0;
    logic [31:0]   wdata = 32'd0;
    logic [31:0]   rdata;
    logic          mem_ready;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dq_out;
    logic [7:0]    sram_dq_in;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    sram8_bridge #(.ADDR_W(AW), .WAIT(WT)) dut (
        .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .mem_ready(mem_ready), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [7:0] sram_mem [MEMSZ];
    logic [7:0] ref_mem  [MEMSZ];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(negedge clk) if (!reset && !sram_we_n) sram_mem[sram_addr] = sram_dq_out;

    typedef struct { logic [31:0] rd; int cy; } rsp_t;
    typedef struct { int a; logic wr; logic [7:0] d; } acc_t;
    rsp_t exp_rsp[$];
    acc_t exp_acc[$];
    logic [31:0] model_rdata = 32'd0;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    function automatic int byte_idx(input logic [29:0] a, input int k);
        logic [31:0] full;
        full = {a, 2'(k)};
        return int'(full % MEMSZ);
    endfunction

    // Called at a negedge; the request cycle is the current cycle
    task automatic issue(input logic [3:0] w, input logic [29:0] a, input logic [31:0] d);
        int n = 0;
        logic [31:0] r = 32'd0;
        rsp_t rs;
        acc_t ac;
        re = 1'b1; we = w; addr = a; wdata = d;
        for (int k = 0; k < 4; k++) begin
            if (w == 4'd0 || w[k]) begin
                ac.a  = byte_idx(a, k);
                ac.wr = (w != 4'd0);
                if (ac.wr) begin
                    ac.d = d[8*k +: 8];
                    ref_mem[ac.a] = ac.d;
                end else begin
                    ac.d = ref_mem[ac.a];
                    r[8*k +: 8] = ac.d;
                end
                exp_acc.push_back(ac);
                n++;
            end
        end
        if (w == 4'd0) model_rdata = r;
        rs.rd = model_rdata;
        rs.cy = cyc + 1 + n * B;
        exp_rsp.push_back(rs);
        @(posedge clk);
        #1;
        re = 1'b0; we = 4'($urandom); addr = 30'($urandom); wdata = $urandom;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (1) begin
            @(negedge clk);
            if (mem_ready) break;
            t++;
            if (t > 200) begin
                n_chk++; n_fail++;
                $display("FAIL ready_timeout: got none expected mem_ready within 200 cycles");
                break;
            end
        end
    endtask

    logic prev_strobe = 1'b0;
    int   slen = 0;
    acc_t last_acc;
    always @(negedge clk) begin
        logic strobe;
        rsp_t rs;
        if (reset) begin
            prev_strobe = 1'b0;
            slen = 0;
        end else begin
            check("we_oe_overlap", 32'(!sram_we_n && !sram_oe_n), 32'd0);
            check("dq_oe_in_read", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
            if (mem_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    rs = exp_rsp.pop_front();
                    check("rdata", rdata, rs.rd);
                    check("ready_cycle", 32'(cyc), 32'(rs.cy));
                    check("ready_ce_n", 32'(sram_ce_n), 32'd1);
                end
            end
            strobe = !sram_we_n || !sram_oe_n;
            if (strobe && !prev_strobe) begin
                if (exp_acc.size() == 0) begin
                    check("unexpected_access", 32'd1, 32'd0);
                end else begin
                    last_acc = exp_acc.pop_front();
                    check("acc_addr", 32'(sram_addr), 32'(last_acc.a));
                    check("acc_kind", 32'(!sram_we_n), 32'(last_acc.wr));
                    check("acc_ce_n", 32'(sram_ce_n), 32'd0);
                    check("acc_dq_oe", 32'(sram_dq_oe), 32'(last_acc.wr));
                    if (last_acc.wr) check("acc_wdata", 32'(sram_dq_out), 32'(last_acc.d));
                end
                slen = 0;
            end
            if (strobe) slen++;
            if (!strobe && prev_strobe) begin
                check("strobe_len", 32'(slen), 32'(WT + 1));
`ifdef SRAM8_BRIDGE_HOLD_EN
                check("hold_ce_n", 32'(sram_ce_n), 32'd0);
                check("hold_addr", 32'(sram_addr), 32'(last_acc.a));
                if (last_acc.wr) begin
                    check("hold_dq_oe", 32'(sram_dq_oe), 32'd1);
                    check("hold_data", 32'(sram_dq_out), 32'(last_acc.d));
                end
`endif
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        logic [3:0]  w;
        logic [29:0] a;
        logic [31:0] d;
        int t;
        for (int i = 0; i < MEMSZ; i++) begin
            sram_mem[i] = 8'($urandom);
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[16] = 8'h11; sram_mem[17] = 8'h22; sram_mem[18] = 8'h33; sram_mem[19] = 8'h44;
        for (int i = 16; i < 20; i++) ref_mem[i] = sram_mem[i];

        #12;
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(4'b0000, 30'd4, 32'd0);
        wait_ready();
        check("dir_read_data", rdata, 32'h44332211);
        repeat (2) @(negedge clk);
        issue(4'b0101, 30'd0, 32'hAABBCCDD);
        wait_ready();
        repeat (2) @(negedge clk);
        issue(4'b1000, 30'd9, 32'h5A000000);
        wait_ready();
        issue(4'b0000, 30'd9, 32'd0);
        wait_ready();
        repeat (2) @(negedge clk);

        // Abort a write mid-strobe; data equals current contents so a partial write is harmless
        a = 30'd20;
        for (int k = 0; k < 4; k++) d[8*k +: 8] = ref_mem[byte_idx(a, k)];
        issue(4'b1111, a, d);
        t = 0;
        while (sram_we_n && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("abort_saw_strobe", 32'(sram_we_n), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_ce_n", 32'(sram_ce_n), 32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_mem_ready", 32'(mem_ready), 32'd0);
        exp_rsp.delete();
        exp_acc.delete();
        model_rdata = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        issue(4'b0000, 30'd4, 32'd0);
        wait_ready();

        for (int i = 0; i < 60; i++) begin
            w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            a = {22'($urandom), 8'($urandom_range(0, 7))};
            d = $urandom;
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(w, a, d);
            wait_ready();
        end

        repeat (5) @(negedge clk);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        check("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram8_bridge.md
# sram8_bridge

Memory-side responder for the CPU's simplified word-addressed memory interface (re / we[3:0] / addr[29:0] / wdata / rdata / mem_ready). It serves each 32-bit word request by performing sequential byte cycles on an external 8-bit asynchronous SRAM, then pulses `mem_ready` for one cycle. It sits between the CPU wrapper and the board SRAM pins; the top level owns the tri-state buffer.

## Interface

Parameters:
- `ADDR_W`, 19: SRAM byte-address width.
- `WAIT`, 1: extra strobe cycles per byte access (strobe lasts WAIT+1 cycles), range 0..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `re`  in  1  request strobe; starts a transaction when sampled while accepting.
- `we`  in  4  byte write enables; nonzero = write of the enabled bytes, 0000 = read.
- `addr`  in  30  word address.
- `wdata`  in  32  write data; byte k = wdata[8k+7:8k].
- `rdata`  out  32  read data, valid in the `mem_ready` cycle of a read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `sram_addr`  out  ADDR_W  SRAM byte address.
- `sram_dq_out`  out  8  data to SRAM.
- `sram_dq_in`  in  8  data from SRAM.
- `sram_dq_oe`  out  1  drive enable for the dq buffer.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low chip enable, output enable, write enable.

## Operation

- States: IDLE, SETUP, STROBE, (HOLD, macro only), DONE.
- Acceptance: `re` is sampled in IDLE and DONE. On acceptance, latch addr, we, wdata; `we` is ignored outside acceptance. `re` in other states is ignored.
- Byte set: read = bytes 0,1,2,3; write = only bytes k with we[k]=1, ascending. Byte k uses SRAM address {addr, k[1:0]} truncated to the low ADDR_W bits.
- SETUP (1 cycle): ce_n=0, sram_addr driven, strobes high; for writes dq_oe=1 and dq_out = byte k.
- STROBE (WAIT+1 cycles, cycle counter): read -> oe_n=0; write -> we_n=0. Reads capture sram_dq_in into rdata[8k+7:8k] at the clock edge ending the last STROBE cycle.
- After the last byte -> DONE: mem_ready=1 for exactly one cycle, ce_n=1, dq_oe=0; otherwise -> SETUP for the next byte.
- DONE with `re`=1 -> SETUP (back-to-back, no bubble); else -> IDLE.
- rdata holds its last value between reads; writes never modify rdata; unread bytes are not cleared.
- All SRAM outputs and mem_ready are registered (glitch-free strobes).

## Timing

- Request cycle = cycle 0. Per byte cost B = WAIT+2 (WAIT+3 with HOLD). mem_ready high in cycle 1 + N*B, where N = bytes accessed (4 for reads, popcount(we) for writes).
- WAIT=1: read -> mem_ready in cycle 13; write with we=0001 -> cycle 4; we=1111 -> cycle 13.
- Reset values: mem_ready 0, rdata 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_ce_n 1, sram_oe_n 1, sram_we_n 1, state IDLE.
- Reset mid-transaction: strobes deasserted asynchronously, transaction abandoned, no mem_ready.
- sram_we_n and sram_oe_n are never low in the same cycle; dq_oe never high during a read.

## Configuration

- `SRAM8_BRIDGE_HOLD_EN` defined: after each STROBE phase one HOLD cycle with ce_n=0, strobes high, address held and (writes) dq_oe=1 and data held; B = WAIT+3.
- Undefined: no HOLD state; STROBE goes directly to the next SETUP or DONE; B = WAIT+2.

## Test plan

- Read, WAIT=1, addr=0x00000004, SRAM bytes 0x10..0x13 = 11,22,33,44 -> sram_addr 0x10,0x11,0x12,0x13 in order, mem_ready in cycle 13, rdata=0x44332211.
- Write we=0101, wdata=0xAABBCCDD, addr=0 -> exactly two we_n pulses, at addr 0 (0xDD) and 2 (0xBB), mem_ready in cycle 7, rdata unchanged.
- Back-to-back: re held high in DONE of a write we=1000 -> next SETUP in the following cycle, no idle cycle.
- WAIT=0 and WAIT=3 reads -> strobe lengths 1 and 4 cycles; mem_ready in cycles 9 and 21.
- Reset asserted in STROBE of a write -> we_n, ce_n go high without a clock edge, dq_oe=0, no mem_ready; next read completes normally.
- With `SRAM8_BRIDGE_HOLD_EN`, WAIT=1 read -> HOLD cycle after each strobe, mem_ready in cycle 17, data held during HOLD on writes.
